// File: rtl/pipeif_fetch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeif_fetch_if : IF-stage bundle (ID control, imem handshake, IF/ID out)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pipeif_fetch_if;
  logic [1:0]  pcsource;
  logic        nostall;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        d_valid;
  logic [31:0] d_inst;
  logic [31:0] d_pc4;

  modport master (
    input  pcsource, nostall, bpc, jpc, ra, imem_ready, imem_rdata,
    output imem_req, imem_addr, d_valid, d_inst, d_pc4
  );

  modport slave (
    output pcsource, nostall, bpc, jpc, ra, imem_ready, imem_rdata,
    input  imem_req, imem_addr, d_valid, d_inst, d_pc4
  );
endinterface
`default_nettype wire

// File: rtl/pipeif_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeif_fetch : MIPS fetch stage + IF/ID register, delayed branch, skid buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipeif_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  pipeif_fetch_if.master  fetch_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] skid_inst_q;
  logic [31:0] skid_pc4_q;
  logic        pend_valid_q;
  logic [31:0] pend_pc_q;
  logic        d_valid_q;
  logic [31:0] d_inst_q;
  logic [31:0] d_pc4_q;

  logic        id_free;
  logic        retire;
  logic        redirect;
  logic        load_mem;
  logic        load_skid;
  logic        load;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] pc_d;

  assign id_free   = ~d_valid_q | fetch_if.nostall;
  assign retire    = d_valid_q & fetch_if.nostall;
  assign redirect  = retire & (fetch_if.pcsource != 2'b00);
  assign load_mem  = (state_q == ST_REQ) & fetch_if.imem_ready & id_free;
  assign load_skid = (state_q == ST_FULL) & id_free;
  assign load      = load_mem | load_skid;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    target = fetch_if.bpc;
    case (fetch_if.pcsource)
      2'b10:   target = fetch_if.ra;
      2'b11:   target = fetch_if.jpc;
      default: target = fetch_if.bpc;
    endcase
  end

  // pc only moves once the delay slot is in IF/ID, so a branch retiring in the
  // same cycle can still steer the fetch after the slot.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect)
      pc_d = target;
    else if (pend_valid_q)
      pc_d = pend_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      skid_inst_q  <= 32'd0;
      skid_pc4_q   <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
      d_valid_q    <= 1'b0;
      d_inst_q     <= 32'd0;
      d_pc4_q      <= 32'd0;
    end else begin
      if (load) begin
        pc_q         <= pc_d;
        pend_valid_q <= 1'b0;
      end else if (redirect) begin
        pend_valid_q <= 1'b1;
        pend_pc_q    <= target;
      end

      if (load_skid) begin
        d_valid_q <= 1'b1;
        d_inst_q  <= skid_inst_q;
        d_pc4_q   <= skid_pc4_q;
      end else if (load_mem) begin
        d_valid_q <= 1'b1;
        d_inst_q  <= fetch_if.imem_rdata;
        d_pc4_q   <= pc_plus4;
      end else if (retire) begin
        d_valid_q <= 1'b0;
        d_inst_q  <= 32'd0;
      end

      case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
        ST_REQ: begin
          if (fetch_if.imem_ready && !id_free) begin
            state_q     <= ST_FULL;
            req_q       <= 1'b0;
            skid_inst_q <= fetch_if.imem_rdata;
            skid_pc4_q  <= pc_plus4;
          end
        end
        ST_FULL: begin
          if (id_free) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_if.imem_req  = req_q;
  assign fetch_if.imem_addr = pc_q;
  assign fetch_if.d_valid   = d_valid_q;
  assign fetch_if.d_inst    = d_inst_q;
  assign fetch_if.d_pc4     = d_pc4_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeif_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipeif_fetch : directed bench for pipeif_fetch (main DUT + wrap DUT)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipeif_fetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipeif_fetch_if fif ();
  pipeif_fetch_if wif ();

  pipeif_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (fif.master)
  );

  pipeif_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (wif.master)
  );

  // Instruction memory: word = address | 0x1000_0000
  assign fif.imem_rdata = fif.imem_addr | 32'h1000_0000;
  assign wif.imem_rdata = wif.imem_addr | 32'h1000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_id(input string tag, input logic [31:0] addr,
                           input logic [31:0] inst, input logic [31:0] pc4);
    check({tag, ".addr"}, fif.imem_addr, addr);
    check({tag, ".inst"}, fif.d_inst, inst);
    check({tag, ".pc4"},  fif.d_pc4, pc4);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    fif.pcsource = 2'b00; fif.nostall = 1'b1; fif.imem_ready = 1'b1;
    fif.bpc = 32'd0; fif.jpc = 32'd0; fif.ra = 32'd0;
    wif.pcsource = 2'b00; wif.nostall = 1'b1; wif.imem_ready = 1'b1;
    wif.bpc = 32'd0; wif.jpc = 32'd0; wif.ra = 32'd0;

    // Reset held with ready asserted
    tick(); tick();
    check("rst.req",   {31'd0, fif.imem_req}, 32'd0);
    check("rst.valid", {31'd0, fif.d_valid}, 32'd0);
    check("rst.inst",  fif.d_inst, 32'd0);
    check("rst.pc4",   fif.d_pc4, 32'd0);

    rst = 1'b0;
    tick();
    check("rel.req",   {31'd0, fif.imem_req}, 32'd1);
    check("rel.addr",  fif.imem_addr, 32'd0);
    check("wrap.addr0", wif.imem_addr, 32'hFFFF_FFFC);

    // Zero-wait stream
    tick();
    expect_id("zw0", 32'h4, 32'h1000_0000, 32'h4);
    check("wrap.addr1", wif.imem_addr, 32'h0000_0000);
    check("wrap.pc4",   wif.d_pc4, 32'h0000_0000);
    check("wrap.inst",  wif.d_inst, 32'hFFFF_FFFC);
    tick();
    expect_id("zw1", 32'h8, 32'h1000_0004, 32'h8);
    tick();
    expect_id("zw2", 32'hC, 32'h1000_0008, 32'hC);

    // Stall: response for 0xC goes to the skid, IF/ID frozen
    fif.nostall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.req", {31'd0, fif.imem_req}, 32'd0);
      expect_id("stall", 32'hC, 32'h1000_0008, 32'hC);
    end
    fif.nostall = 1'b1;
    tick();
    check("drain.req", {31'd0, fif.imem_req}, 32'd1);
    expect_id("drain", 32'h10, 32'h1000_000C, 32'h10);

    // Bypass branch: beq at 0x10 retires while delay slot 0x14 arrives
    tick();
    expect_id("beq", 32'h14, 32'h1000_0010, 32'h14);
    fif.pcsource = 2'b01; fif.bpc = 32'h40;
    tick();
    expect_id("slot", 32'h40, 32'h1000_0014, 32'h18);
    fif.pcsource = 2'b00;
    tick();
    expect_id("tgt", 32'h44, 32'h1000_0040, 32'h44);
    tick();
    expect_id("jrid", 32'h48, 32'h1000_0044, 32'h48);

    // Pending jr: delay slot fetch at 0x48 waits 3 cycles
    fif.pcsource = 2'b10; fif.ra = 32'h100; fif.imem_ready = 1'b0;
    tick();
    check("jr.bubble", {31'd0, fif.d_valid}, 32'd0);
    check("jr.inst",   fif.d_inst, 32'd0);
    check("jr.hold",   fif.imem_addr, 32'h48);
    // Redirect inputs must be ignored while IF/ID is empty
    fif.pcsource = 2'b11; fif.jpc = 32'h999;
    tick();
    check("jr.wait1", fif.imem_addr, 32'h48);
    tick();
    check("jr.wait2", fif.imem_addr, 32'h48);
    check("jr.req",   {31'd0, fif.imem_req}, 32'd1);
    fif.pcsource = 2'b00; fif.imem_ready = 1'b1;
    tick();
    expect_id("jr.slot", 32'h100, 32'h1000_0048, 32'h4C);
    tick();
    expect_id("jr.tgt", 32'h104, 32'h1000_0100, 32'h104);

    // Pending j
    fif.pcsource = 2'b11; fif.jpc = 32'h200; fif.imem_ready = 1'b0;
    tick();
    check("j.bubble", {31'd0, fif.d_valid}, 32'd0);
    fif.pcsource = 2'b00; fif.imem_ready = 1'b1;
    tick();
    expect_id("j.slot", 32'h200, 32'h1000_0104, 32'h108);
    tick();
    expect_id("j.tgt", 32'h204, 32'h1000_0200, 32'h204);

    // Mid-fetch reset during a long wait
    fif.imem_ready = 1'b0;
    tick(); tick();
    check("mr.hold", fif.imem_addr, 32'h204);
    rst = 1'b1;
    #1;
    check("mr.req",   {31'd0, fif.imem_req}, 32'd0);
    check("mr.valid", {31'd0, fif.d_valid}, 32'd0);
    check("mr.inst",  fif.d_inst, 32'd0);
    check("mr.pc4",   fif.d_pc4, 32'd0);
    check("mr.addr",  fif.imem_addr, 32'd0);
    fif.imem_ready = 1'b1;
    tick();
    check("mr.stale", {31'd0, fif.d_valid}, 32'd0);
    rst = 1'b0;
    tick();
    check("mr.req1",  {31'd0, fif.imem_req}, 32'd1);
    check("mr.addr1", fif.imem_addr, 32'd0);
    tick();
    expect_id("mr.first", 32'h4, 32'h1000_0000, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
